// File: rtl/data_sram_bridge_pkg.sv
// Shared encodings and lane helpers for the MIPS data/instruction SRAM bridges.
// Package name mips_mem_pkg is kept so both bridges import the same definitions.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } bridge_state_t;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            default:   return |offset;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_bridge_load_align.sv
// Combinational load extractor: picks the addressed byte/half of a bus word and
// sign- or zero-extends it. Shared with the instruction-side bridge.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (offset)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        result = bus_rdata;
        case (size)
            SIZE_BYTE: result = {{24{sign & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{16{sign & half_sel[15]}}, half_sel};
            default:   result = bus_rdata;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Memory-stage load/store bridge onto a handshaked data SRAM bus.
// Optional bus watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module data_sram_bridge
    import mips_mem_pkg::*;
#(
    parameter int unsigned PHYS_MAP       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wen,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_adel,
    output logic        mem_ades,
    output logic        mem_buserr,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("data_sram_bridge: TIMEOUT_CYCLES out of range 1..65535");
    end

    bridge_state_t state;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          sign_q;

    logic          misaligned;
    logic          accept;
    logic          busy;
    logic          complete;
    logic          timeout;
    logic [31:0]   phys_addr;
    logic [31:0]   load_data;

    assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
    assign accept     = (state == IDLE) & mem_en & ~misaligned;
    assign busy       = (state == ADDR) | (state == DATA);
    assign complete   = ((state == ADDR) & bus_addr_ok & bus_data_ok)
                      | ((state == DATA) & bus_data_ok);

    assign mem_adel  = mem_en & ~mem_wen & misaligned;
    assign mem_ades  = mem_en & mem_wen & misaligned;
    assign mem_stall = accept | busy;

    assign phys_addr = (PHYS_MAP != 0) ? (mem_addr & PHYS_MASK) : mem_addr;

    load_align u_load_align (
        .bus_rdata (bus_rdata),
        .offset    (off_q),
        .size      (size_q),
        .sign      (sign_q),
        .result    (load_data)
    );

`ifdef BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th cycle spent in ADDR/DATA.
    assign timeout = busy & (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_buserr <= 1'b0;
        end else begin
            mem_buserr <= timeout & ~complete;
        end
    end
`else
    assign timeout    = 1'b0;
    assign mem_buserr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            mem_rdata <= '0;
            off_q     <= '0;
            size_q    <= '0;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= mem_wen;
                        bus_addr  <= {phys_addr[31:2], 2'b00};
                        bus_wstrb <= mem_wen ? lane_strb(mem_size, mem_addr[1:0]) : 4'b0000;
                        bus_wdata <= lane_wdata(mem_size, mem_wdata);
                        off_q     <= mem_addr[1:0];
                        size_q    <= mem_size;
                        sign_q    <= mem_sign;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (complete) begin
                        bus_req <= 1'b0;
                        if (!bus_wr) mem_rdata <= load_data;
                        state   <= DONE;
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (complete) begin
                        if (!bus_wr) mem_rdata <= load_data;
                        state <= DONE;
                    end else if (timeout) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed scoreboard bench for data_sram_bridge; the timeout step runs only
// when BRIDGE_TIMEOUT_EN is defined.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_wen = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_sign = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_adel;
    logic        mem_ades;
    logic        mem_buserr;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    data_sram_bridge #(
        .PHYS_MAP       (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_wen     (mem_wen),
        .mem_size    (mem_size),
        .mem_sign    (mem_sign),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_stall   (mem_stall),
        .mem_adel    (mem_adel),
        .mem_ades    (mem_ades),
        .mem_buserr  (mem_buserr),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wstrb   (bus_wstrb),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strb_model(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b00) return 4'b0001 << off;
        if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {4{d[7:0]}};
        if (sz == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = rd >> (8 * off);
        if (sz == 2'b00) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        if (sz == 2'b01) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return rd;
    endfunction

    // One aligned access: a_wait idle cycles before addr_ok, data_ok d_wait cycles after it.
    task automatic access(input string tag, input logic [1:0] sz, input logic sg, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int a_wait, input int d_wait, input logic [31:0] exp_rdata,
                          input int exp_stalls, input logic exp_berr);
        exp_t e;
        exp_t got;
        int   stalls;
        bit   done;
        e.addr  = addr & 32'h1FFF_FFFC;
        e.wr    = wr;
        e.strb  = wr ? strb_model(sz, addr[1:0]) : 4'b0000;
        e.wdata = wdata_model(sz, wd);
        e.rdata = exp_rdata;
        sb.push_back(e);
        @(negedge clk);
        mem_en = 1'b1; mem_wen = wr; mem_size = sz; mem_sign = sg;
        mem_addr = addr; mem_wdata = wd;
        #1;
        check({tag, ".stall0"}, mem_stall, 1'b1);
        check({tag, ".req0"}, bus_req, 1'b0);
        stalls = 1;
        done = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (!mem_stall) begin
                done = 1;
            end else begin
                stalls++;
                if (c == 1) begin
                    got = sb.pop_front();
                    check({tag, ".req"}, bus_req, 1'b1);
                    check({tag, ".addr"}, bus_addr, got.addr);
                    check({tag, ".wr"}, bus_wr, got.wr);
                    check({tag, ".strb"}, bus_wstrb, got.strb);
                    if (got.wr) check({tag, ".wdata"}, bus_wdata, got.wdata);
                end
                if (c == 1 + a_wait) begin
                    bus_addr_ok = 1'b1;
                    if (d_wait == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata = rd;
                    end
                end else if (d_wait > 0 && c == 1 + a_wait + d_wait) begin
                    bus_data_ok = 1'b1;
                    bus_rdata = rd;
                end
            end
        end
        check({tag, ".finished"}, done, 1'b1);
        check({tag, ".stalls"}, stalls, exp_stalls);
        check({tag, ".rdata"}, mem_rdata, got.rdata);
        check({tag, ".buserr"}, mem_buserr, exp_berr);
        check({tag, ".req_done"}, bus_req, 1'b0);
        mem_en = 1'b0;
        last_rdata = exp_rdata;
    endtask

    task automatic misalign(input string tag, input logic [1:0] sz, input logic wr, input logic [31:0] addr);
        @(negedge clk);
        mem_en = 1'b1; mem_wen = wr; mem_size = sz; mem_addr = addr;
        #1;
        check({tag, ".adel"}, mem_adel, !wr);
        check({tag, ".ades"}, mem_ades, wr);
        check({tag, ".stall"}, mem_stall, 1'b0);
        @(negedge clk);
        check({tag, ".req"}, bus_req, 1'b0);
        check({tag, ".stall_hold"}, mem_stall, 1'b0);
        mem_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a, wd, rd, er;
        logic        wr, sg;
        int          aw, dw;

        repeat (2) @(negedge clk);
        check("rst.req", bus_req, 1'b0);
        check("rst.wr", bus_wr, 1'b0);
        check("rst.addr", bus_addr, 32'h0);
        check("rst.strb", bus_wstrb, 4'h0);
        check("rst.wdata", bus_wdata, 32'h0);
        check("rst.rdata", mem_rdata, 32'h0);
        check("rst.buserr", mem_buserr, 1'b0);
        check("rst.stall", mem_stall, 1'b0);
        rst = 1'b1;

        access("lw_kseg0", 2'b10, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 4, 1'b0);
        access("lb_signed", 2'b00, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 1, 1, 32'hFFFF_FF80, 4, 1'b0);
        access("lbu", 2'b00, 1'b0, 1'b0, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 0, 0, 32'h0000_0080, 2, 1'b0);
        access("sh", 2'b01, 1'b0, 1'b1, 32'h0000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1, last_rdata, 3, 1'b0);
        access("lh_kseg1", 2'b01, 1'b1, 1'b0, 32'hA000_0002, 32'h0, 32'h8001_1234, 2, 1, 32'hFFFF_8001, 5, 1'b0);
        access("sb", 2'b00, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_005A, 32'h0, 0, 1, last_rdata, 3, 1'b0);
        access("lw_size3", 2'b11, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h1357_9BDF, 0, 1, 32'h1357_9BDF, 3, 1'b0);

        misalign("lw_mis", 2'b10, 1'b0, 32'h0000_0002);
        misalign("sh_mis", 2'b01, 1'b1, 32'h0000_0001);

        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            rd = $urandom;
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            er = wr ? last_rdata : load_model(rd, a[1:0], sz, sg);
            access("rand", sz, sg, wr, a, wd, rd, aw, dw, er, 2 + aw + dw, 1'b0);
        end

        // Reset while waiting in DATA, then a stale data_ok arrives.
        @(negedge clk);
        mem_en = 1'b1; mem_wen = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0040;
        @(negedge clk);
        check("rstmid.req", bus_req, 1'b1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        check("rstmid.data_state", bus_req, 1'b0);
        check("rstmid.data_stall", mem_stall, 1'b1);
        rst = 1'b0;
        #1;
        check("rstmid.req_rst", bus_req, 1'b0);
        check("rstmid.addr_rst", bus_addr, 32'h0);
        check("rstmid.rdata_rst", mem_rdata, 32'h0);
        check("rstmid.stall_en", mem_stall, 1'b1);
        mem_en = 1'b0;
        #1;
        check("rstmid.stall_noen", mem_stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_data_ok = 1'b0;
        check("rstmid.late_rdata", mem_rdata, 32'h0);
        check("rstmid.late_req", bus_req, 1'b0);
        check("rstmid.late_stall", mem_stall, 1'b0);
        last_rdata = 32'h0;

        access("lw_after_rst", 2'b10, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 3, 1'b0);

`ifdef BRIDGE_TIMEOUT_EN
        access("timeout", 2'b10, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_2222, 0, 1000, last_rdata, 9, 1'b1);
        @(negedge clk);
        check("timeout.pulse_end", mem_buserr, 1'b0);
        check("timeout.idle_stall", mem_stall, 1'b0);
`endif

        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
